// File: rtl/wb_lsu_master_pkg.sv
// Shared definitions for the LSU Wishbone initiator and the tagged RAM slave:
// lane-select codes, request size codes, error codes and FSM states.
package wb_lsu_master_pkg;

  localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
  localparam logic [3:0] WB_SEL_HALF = 4'b0011;
  localparam logic [3:0] WB_SEL_WORD = 4'b1111;
  localparam logic [3:0] WB_SEL_TAG  = 4'b0101;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_TAG  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP_ERR,
    S_GAP
  } state_e;

  function automatic logic [3:0] size_to_sel(size_e size);
    logic [3:0] sel;
    unique case (size)
      SIZE_BYTE: sel = WB_SEL_BYTE;
      SIZE_HALF: sel = WB_SEL_HALF;
      SIZE_WORD: sel = WB_SEL_WORD;
      default:   sel = WB_SEL_TAG;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_load_extend.sv
// Combinational sign/zero extension of right-justified Wishbone read data
// according to the access size; tag reads keep only the 4-bit tag.
module wb_load_extend
  import wb_lsu_master_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e             size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    unique case (size_i)
      SIZE_BYTE: data_o = {{(DATA_W-8){data_i[7] & ~unsigned_i}}, data_i[7:0]};
      SIZE_HALF: data_o = {{(DATA_W-16){data_i[15] & ~unsigned_i}}, data_i[15:0]};
      SIZE_WORD: data_o = data_i;
      default:   data_o = {{(DATA_W-4){1'b0}}, data_i[3:0]};
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-beat Wishbone initiator for core load/store/tag requests, with
// alignment check, bus timeout and a post-ack hold gap for the tag checker.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int WB_DATA_WIDTH      = 32,
  parameter int WB_ADDR_WIDTH      = 32,
  parameter int WB_SEL_WIDTH       = WB_DATA_WIDTH / 8,
  parameter int GRANULE_SIZE_BYTES = 16,
  parameter int TIMEOUT_CYCLES     = 16,
  parameter int GAP_CYCLES         = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                     resp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] resp_rdata_o,
  output logic                     resp_err_o,
  output logic [1:0]               resp_err_code_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WB_ADDR_WIDTH-1:0] GRAN_MASK =
    WB_ADDR_WIDTH'(GRANULE_SIZE_BYTES - 1);

  state_e                   state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0] data_q, data_d;
  logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                     we_q, we_d;
  size_e                    size_q, size_d;
  logic                     uns_q, uns_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     rvalid_q, rvalid_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [1:0]               code_q, code_d;
  logic [WB_DATA_WIDTH-1:0] ext_data;
  size_e                    req_size;

  assign req_size = size_e'(req_size_i);

  function automatic logic is_aligned(size_e size, logic [WB_ADDR_WIDTH-1:0] addr);
    logic ok;
    unique case (size)
      SIZE_HALF: ok = ~addr[0];
      SIZE_WORD: ok = (addr[1:0] == 2'b00);
      SIZE_TAG:  ok = ((addr & GRAN_MASK) == '0);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

  wb_load_extend #(
    .DATA_W(WB_DATA_WIDTH)
  ) u_extend (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_i    (wb_data_i),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (is_aligned(req_size, req_addr_i)) begin
            addr_d  = req_addr_i;
            data_d  = req_wdata_i;
            sel_d   = WB_SEL_WIDTH'(size_to_sel(req_size));
            we_d    = req_we_i;
            size_d  = req_size;
            uns_d   = req_unsigned_i;
            tmo_d   = '0;
            state_d = S_BUS;
          end else begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            code_d   = ERR_MISALIGN;
            state_d  = S_RESP_ERR;
          end
        end
      end
      S_BUS: begin
        // Ack has priority over a timeout landing on the same cycle.
        if (wb_ack_i || tmo_q == TMO_LAST) begin
          rvalid_d = 1'b1;
          gap_d    = '0;
          state_d  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          if (wb_ack_i) begin
            rdata_d = we_q ? '0 : ext_data;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP_ERR: state_d = S_IDLE;
      default: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= SIZE_BYTE;
      uns_q    <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign wb_cyc_o        = (state_q == S_BUS);
  assign wb_stb_o        = (state_q == S_BUS);
  assign wb_addr_o       = addr_q;
  assign wb_data_o       = data_q;
  assign wb_sel_o        = sel_q;
  assign wb_we_o         = we_q;
  assign resp_valid_o    = rvalid_q;
  assign resp_rdata_o    = rdata_q;
  assign resp_err_o      = err_q;
  assign resp_err_code_o = code_q;

endmodule
